axi_burst_sequencer: RTL
========================

AXI_BURST_SEQUENCER -- requirements
Module: axi_burst_sequencer

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address and byte-count width.
REQ-002 SHALL have parameter DW, default 32, meaning data-bus width in bits (8..1024, power of 2); BPB = DW/8 bytes per beat.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: transfer request valid.
REQ-006 SHALL have port req_ready, output, 1: sequencer accepts request.
REQ-007 SHALL have port req_addr, input, AW: start byte address.
REQ-008 SHALL have port req_byte_count, input, AW: total bytes to move.
REQ-009 SHALL have port req_fixed, input, 1: 1 = FIXED burst (constant address), 0 = INCR.
REQ-010 SHALL have port ax_valid, output, 1: AXI address-channel valid.
REQ-011 SHALL have port ax_ready, input, 1: AXI address-channel ready.
REQ-012 SHALL have port ax_addr, output, AW: burst start address.
REQ-013 SHALL have port ax_len, output, 8: beats minus one (AXI LEN encoding).
REQ-014 SHALL have port ax_size, output, 3: log2(BPB), constant.
REQ-015 SHALL have port ax_burst, output, 2: AXI burst encoding from the shared AXI package (FIXED 2'b00, INCR 2'b01); WRAP and RESERVED never driven.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after last burst handshake.
REQ-017 SHALL have port err, output, 1: one-cycle pulse on rejected request.

Function
REQ-018 SHALL implement states IDLE and ISSUE; req_ready = 1 only in IDLE; ax_valid = 1 only in ISSUE.
REQ-019 SHALL in IDLE on req_valid && req_ready latch addr, remaining beats = req_byte_count/BPB and mode; enter ISSUE next cycle.
REQ-020 SHALL reject a request if req_addr or req_byte_count is not a multiple of BPB, or req_byte_count == 0: pulse err the next cycle, stay IDLE, issue no burst.
REQ-021 SHALL in INCR compute beats = min(remaining, 256, (4096 - addr[11:0])/BPB); no burst crosses a 4 KB boundary.
REQ-022 SHALL in FIXED compute beats = min(remaining, 16); ax_addr constant for all bursts of the request.
REQ-023 SHALL drive ax_len = beats - 1; ax_addr, ax_len, ax_burst, ax_size stable while ax_valid && !ax_ready.
REQ-024 SHALL on ax_valid && ax_ready subtract beats from remaining and (INCR only) advance addr by beats*BPB, using AW-bit arithmetic that wraps modulo 2^AW.
REQ-025 SHALL on the handshake that makes remaining = 0 return to IDLE and pulse done in the following cycle; req_ready reasserts that same following cycle.
REQ-026 SHALL allow back-to-back bursts: a new ax_valid beat is presented the cycle after each non-final handshake (ax_valid stays high).
REQ-027 SHALL ignore req_valid while in ISSUE; req_* inputs are sampled only at acceptance.
REQ-028 SHALL support remaining up to 2^AW/BPB - 1 beats without overflow.

Reset
REQ-029 SHALL on rst force IDLE, req_ready = 1, ax_valid = 0, done = 0, err = 0, ax_addr = 0, ax_len = 0, ax_burst = INCR, remaining = 0 from the next cycle.
REQ-030 SHALL on rst asserted mid-ISSUE abandon the request, with no done and no err pulse.

Verification (DW=32, BPB=4)
REQ-031 SHALL test addr 0x1000, count 0x400, INCR -> one burst addr 0x1000 len 0xFF burst 01 size 2, then done.
REQ-032 SHALL test addr 0x0FF0, count 0x20, INCR -> bursts (0x0FF0, len 3), (0x1000, len 3), then done.
REQ-033 SHALL test addr 0x0, count 0x1000, INCR -> four bursts len 0xFF at 0x0, 0x400, 0x800, 0xC00, back-to-back with ax_ready held high.
REQ-034 SHALL test addr 0x2000, count 0x50, FIXED -> bursts (0x2000, len 15, burst 00), (0x2000, len 3), then done.
REQ-035 SHALL test addr 0x2 or count 0 -> err pulse, no ax_valid, req_ready high again.
REQ-036 SHALL test ax_ready low 5 cycles -> ax_* stable; rst during ISSUE -> ax_valid 0 and req_ready 1 next cycle, with no done and no err pulse.

Source files
------------

// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer: splits byte-count transfer requests into AXI INCR/FIXED address bursts
module axi_burst_sequencer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_byte_count,
  input  logic          req_fixed,
  output logic          ax_valid,
  input  logic          ax_ready,
  output logic [AW-1:0] ax_addr,
  output logic [7:0]    ax_len,
  output logic [2:0]    ax_size,
  output logic [1:0]    ax_burst,
  output logic          done,
  output logic          err
);
  localparam int BPB = DW / 8;
  localparam int SZ = $clog2(BPB);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, next;
  logic [AW-1:0] addr, rem;
  logic fixed, hs, last, bad, take;
  logic [12:0] pg, cap, lim;
  logic [8:0] beats;
  // burst sizing: FIXED caps at 16 beats, INCR at 256 beats and the next 4 KB page
  always_comb begin
    pg = 13'(13'h1000 - {1'b0, addr[11:0]}) >> SZ;
    cap = fixed ? 13'd16 : 13'd256;
    lim = (fixed || cap < pg) ? cap : pg;
    beats = (rem < AW'(lim)) ? rem[8:0] : lim[8:0];
    hs = state == ISSUE && ax_ready;
    last = hs && rem == AW'(beats);
    bad = |(req_addr & AW'(BPB - 1)) || |(req_byte_count & AW'(BPB - 1)) || req_byte_count == '0;
    take = state == IDLE && req_valid;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  // next state: accept good requests, leave ISSUE on the final handshake
  always_comb begin
    next = state == IDLE ? ((req_valid && !bad) ? ISSUE : IDLE) : (last ? IDLE : ISSUE);
  end
  // outputs derive from registered state so they hold steady while stalled
  always_comb begin
    req_ready = state == IDLE;
    ax_valid = state == ISSUE;
    ax_addr = addr;
    ax_len = ax_valid ? 8'(beats - 9'd1) : 8'd0;
    ax_burst = fixed ? BURST_FIXED : BURST_INCR;
    ax_size = 3'(SZ);
  end
  // request latch, per-handshake bookkeeping and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      rem <= '0;
      fixed <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= last;
      err <= take && bad;
      if (take && !bad) begin
        addr <= req_addr;
        rem <= req_byte_count >> SZ;
        fixed <= req_fixed;
      end else if (hs) begin
        rem <= rem - AW'(beats);
        if (!fixed) addr <= addr + (AW'(beats) << SZ);
      end
    end
  end
endmodule
